composite_sync_generator: RTL

// Synthesizes a 12-bit 240p composite video sample stream (sync tip, blanking, burst, active luma).
// One sample is produced per sample_valid strobe.

---
 rtl/composite_sync_generator_if.sv | 25 ++
 rtl/composite_sync_generator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/composite_sync_generator_if.sv
// Sample-strobe, pixel-request and composite-output signals of the composite sync generator.
// The master drives strobe, control and pixel inputs; the slave (generator) drives video outputs.
interface composite_sync_generator_if;
  logic        sample_valid;
  logic        run;
  logic        pattern_en;
  logic [7:0]  pixel_in;
  logic        pixel_req;
  logic [11:0] dac_data;
  logic        sync_n;
  logic        line_start;
  logic        frame_start;
  logic [11:0] h_count;
  logic [8:0]  v_count;

  modport master (
    output sample_valid, run, pattern_en, pixel_in,
    input  pixel_req, dac_data, sync_n, line_start, frame_start, h_count, v_count
  );

  modport slave (
    input  sample_valid, run, pattern_en, pixel_in,
    output pixel_req, dac_data, sync_n, line_start, frame_start, h_count, v_count
  );
endinterface

// File: rtl/composite_sync_generator.sv
// 12-bit 240p composite video generator: sync tip, burst, blanking and active luma,
// one sample per sample_valid strobe, driven by a per-line segment FSM.
module composite_sync_generator #(
  parameter int unsigned LINE_TOTAL      = 2350,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned ACTIVE_LINES    = 240,
  parameter int unsigned VSYNC_LINE      = 244,
  parameter int unsigned VSYNC_LINES     = 3,
  parameter int unsigned HSYNC_WIDTH     = 174,
  parameter int unsigned BURST_START     = 25,
  parameter int unsigned BURST_END       = 110,
  parameter int unsigned BURST_HALF      = 5,
  parameter int unsigned BACK_PORCH      = 222,
  parameter int unsigned ACTIVE_WIDTH    = 1920,
  parameter int unsigned SYNC_LEVEL      = 200,
  parameter int unsigned BLANK_LEVEL     = 1200,
  parameter int unsigned BURST_AMP       = 150
) (
  input logic                       clk,
  input logic                       rst,
  composite_sync_generator_if.slave bus
);

  localparam logic [11:0] LastH        = 12'(LINE_TOTAL - 1);
  localparam logic [8:0]  LastV        = 9'(LINES_PER_FRAME - 1);
  localparam logic [11:0] SyncLastH    = 12'(HSYNC_WIDTH - 1);
  localparam logic [11:0] BroadLastH   = 12'(LINE_TOTAL - HSYNC_WIDTH - 1);
  localparam logic [11:0] BurstPrevH   = 12'(HSYNC_WIDTH + BURST_START);
  localparam logic [11:0] BurstFirstH  = 12'(HSYNC_WIDTH + BURST_START + 1);
  localparam logic [11:0] BurstLastH   = 12'(HSYNC_WIDTH + BURST_END - 1);
  localparam logic [11:0] ActFirstH    = 12'(HSYNC_WIDTH + BACK_PORCH + 1);
  localparam logic [11:0] ActLastH     = 12'(HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH);
  localparam logic [8:0]  ActLines     = 9'(ACTIVE_LINES);
  localparam logic [8:0]  VsFirst      = 9'(VSYNC_LINE);
  localparam logic [8:0]  VsLast       = 9'(VSYNC_LINE + VSYNC_LINES - 1);
  localparam logic [7:0]  BurstLastCnt = 8'(BURST_HALF - 1);
  localparam logic [11:0] SyncCode     = 12'(SYNC_LEVEL);
  localparam logic [11:0] BlankCode    = 12'(BLANK_LEVEL);
  localparam logic [11:0] BurstHiCode  = 12'(BLANK_LEVEL + BURST_AMP);
  localparam logic [11:0] BurstLoCode  = 12'(BLANK_LEVEL - BURST_AMP);
  localparam logic [12:0] BlankWide    = 13'(BLANK_LEVEL);

  typedef enum logic [2:0] {
    StSync,
    StPorch,
    StFront,
    StBroadLo,
    StBroadHi
  } seg_e;

  seg_e        r_seg;
  logic [11:0] r_h;
  logic [8:0]  r_v;
  logic [7:0]  r_burst_cnt;
  logic        r_burst_neg;
  logic [11:0] r_dac;
  logic        r_sync_n;
  logic        r_line_start;
  logic        r_frame_start;

  seg_e        w_seg_nxt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [11:0] w_h_nxt;
  logic [8:0]  w_v_nxt;
  logic        w_broad_nxt;
  logic        w_in_burst;
  logic        w_active;
  logic [11:0] w_ramp;
  logic [7:0]  w_luma;
  logic [12:0] w_luma_sum;
  logic [11:0] w_luma_code;
  logic [11:0] w_dac_nxt;
  logic        w_sync_n_nxt;

  assign w_h_wrap    = (r_h == LastH);
  assign w_v_wrap    = (r_v == LastV);
  assign w_h_nxt     = w_h_wrap ? 12'd0 : r_h + 12'd1;
  assign w_v_nxt     = !w_h_wrap ? r_v : (w_v_wrap ? 9'd0 : r_v + 9'd1);
  assign w_broad_nxt = (w_v_nxt >= VsFirst) && (w_v_nxt <= VsLast);

  // Burst and active windows live inside the porch segment; broad lines never reach it.
  assign w_in_burst = (r_seg == StPorch) && (r_h >= BurstFirstH) && (r_h <= BurstLastH);
  assign w_active   = (r_seg == StPorch) && (r_v < ActLines) &&
                      (r_h >= ActFirstH) && (r_h <= ActLastH);

  assign w_ramp      = r_h - ActFirstH;
  assign w_luma      = bus.pattern_en ? 8'(w_ramp >> 3) : bus.pixel_in;
  assign w_luma_sum  = BlankWide + {3'b000, w_luma, 2'b00};
  assign w_luma_code = w_luma_sum[12] ? 12'hFFF : w_luma_sum[11:0];

  always_comb begin
    w_seg_nxt    = r_seg;
    w_dac_nxt    = BlankCode;
    w_sync_n_nxt = 1'b1;
    unique case (r_seg)
      StSync: begin
        w_dac_nxt    = SyncCode;
        w_sync_n_nxt = 1'b0;
        if (r_h == SyncLastH) w_seg_nxt = StPorch;
      end
      StPorch: begin
        if (w_in_burst) begin
          w_dac_nxt = r_burst_neg ? BurstLoCode : BurstHiCode;
        end else if (w_active) begin
          w_dac_nxt = w_luma_code;
        end
        if (r_h == ActLastH) w_seg_nxt = StFront;
      end
      StBroadLo: begin
        w_dac_nxt    = SyncCode;
        w_sync_n_nxt = 1'b0;
        if (r_h == BroadLastH) w_seg_nxt = StBroadHi;
      end
      StFront, StBroadHi: begin
        if (w_h_wrap) w_seg_nxt = w_broad_nxt ? StBroadLo : StSync;
      end
      default: w_seg_nxt = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg         <= StSync;
      r_h           <= 12'd0;
      r_v           <= 9'd0;
      r_burst_cnt   <= 8'd0;
      r_burst_neg   <= 1'b0;
      r_dac         <= BlankCode;
      r_sync_n      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!bus.run) begin
      r_seg         <= StSync;
      r_h           <= 12'd0;
      r_v           <= 9'd0;
      r_burst_cnt   <= 8'd0;
      r_burst_neg   <= 1'b0;
      r_dac         <= BlankCode;
      r_sync_n      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= bus.sample_valid && w_h_wrap;
      r_frame_start <= bus.sample_valid && w_h_wrap && w_v_wrap;
      if (bus.sample_valid) begin
        r_seg    <= w_seg_nxt;
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_dac    <= w_dac_nxt;
        r_sync_n <= w_sync_n_nxt;
        // Phase restarts on the sample just before the window so it opens on +BURST_AMP.
        if (r_h == BurstPrevH) begin
          r_burst_cnt <= 8'd0;
          r_burst_neg <= 1'b0;
        end else if (w_in_burst) begin
          if (r_burst_cnt == BurstLastCnt) begin
            r_burst_cnt <= 8'd0;
            r_burst_neg <= ~r_burst_neg;
          end else begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bus.pixel_req   = bus.run & w_active;
  assign bus.dac_data    = r_dac;
  assign bus.sync_n      = r_sync_n;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.h_count     = r_h;
  assign bus.v_count     = r_v;

endmodule
